// File: rtl/bus_read_mux.sv
// bus_read_mux: registered read-data mux with chip-select decode and per-read timeout.
// Optional BUS_READ_MUX_MULTIHIT_ERR_EN turns multiple low chip selects into a decode error.
module bus_read_mux #(
    parameter int NUM_SLV = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [NUM_SLV-1:0]    cs_n,
    input  logic [NUM_SLV*DW-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_ready,
    output logic [DW-1:0]         read_data,
    output logic                  read_valid,
    output logic                  read_err,
    output logic                  busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(NUM_SLV);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, nxt;
    logic [SW-1:0]   sel, low_sel;
    logic [CW-1:0]   cnt;
    logic            err, dec_err, rdy, tmo;
    logic [DW-1:0]   sel_data;

    always_comb begin
        low_sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--)
            if (!cs_n[i]) low_sel = SW'(i);
    end

`ifdef BUS_READ_MUX_MULTIHIT_ERR_EN
    logic [NUM_SLV-1:0] cs_lo;
    assign cs_lo   = ~cs_n;
    // x & (x-1) is nonzero exactly when more than one bit is set
    assign dec_err = (&cs_n) | (|(cs_lo & (cs_lo - NUM_SLV'(1))));
`else
    assign dec_err = &cs_n;
`endif

    assign rdy      = slv_ready[sel];
    assign sel_data = slv_rdata[sel*DW +: DW];
    assign tmo      = cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE) ? (rd_en ? (dec_err ? RESP : WAIT) : IDLE) :
              (state == WAIT) ? ((rdy || tmo) ? RESP : WAIT) :
                                IDLE;
    end

    always_comb begin
        read_valid = state == RESP;
        read_err   = (state == RESP) && err;
        busy       = state != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: if (rd_en) begin
                    if (dec_err) begin
                        read_data <= '0;
                        err       <= 1'b1;
                    end else begin
                        sel <= low_sel;
                        cnt <= '0;
                    end
                end
                WAIT: if (rdy) begin
                    read_data <= sel_data;
                    err       <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (tmo) begin
                        read_data <= '0;
                        err       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_read_mux.sv
// tb_bus_read_mux: directed stimulus with a queue-based scoreboard checking data, error and response cycle.
module tb_bus_read_mux;
    localparam int NS = 4;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_en;
    logic [NS-1:0]    cs_n;
    logic [NS*DW-1:0] slv_rdata;
    logic [NS-1:0]    slv_ready;
    logic [DW-1:0]    read_data;
    logic             read_valid, read_err, busy;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    bus_read_mux #(.NUM_SLV(NS), .DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .cs_n(cs_n),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready),
        .read_data(read_data), .read_valid(read_valid),
        .read_err(read_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (read_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got read_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_cycle", cyc, mon_e.cyc);
                    chk("resp_data", read_data, mon_e.d);
                    chk("resp_err", {31'b0, read_err}, {31'b0, mon_e.e});
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: got no response expected one at cycle %0d (now %0d)", mon_e.cyc, cyc);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [NS-1:0] cs, input logic [31:0] d, input logic e,
                         input int lat, input bit push);
        exp_t x;
        rd_en = 1'b1;
        cs_n  = cs;
        if (push) begin
            x.cyc = cyc + lat;
            x.d   = d;
            x.e   = e;
            q.push_back(x);
        end
        step(1);
        rd_en = 1'b0;
    endtask

    task automatic drive(input int s, input logic [31:0] d);
        slv_rdata[s*DW +: DW] = d;
        slv_ready[s]          = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; cs_n = '1; slv_rdata = '0; slv_ready = '0;
        step(2);
        chk("rst_data", read_data, 32'h0);
        chk("rst_valid", {31'b0, read_valid}, 32'h0);
        chk("rst_err", {31'b0, read_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        // first cycle after reset release; other slaves ready with junk must be ignored
        issue(4'b1101, 32'hDEADBEEF, 1'b0, 2, 1);
        chk("busy_wait", {31'b0, busy}, 32'h1);
        drive(0, 32'h11111111); drive(1, 32'hDEADBEEF); drive(3, 32'h33333333);
        step(1);
        slv_ready = '0;
        step(3);
        chk("data_hold", read_data, 32'hDEADBEEF);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        // decode error
        issue(4'b1111, 32'h0, 1'b1, 1, 1);
        step(3);
        // timeout with rd_en retries, cs_n changes and a ready from a non-selected slave
        issue(4'b0111, 32'h0, 1'b1, 17, 1);
        cs_n = 4'b1110;
        drive(0, 32'h55555555);
        step(2);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        step(18);
        slv_ready = '0;
        chk("tmo_hold", read_data, 32'h0);
        // ready on the last WAIT cycle beats the timeout
        issue(4'b0111, 32'hCAFE0003, 1'b0, 17, 1);
        step(15);
        drive(3, 32'hCAFE0003);
        step(1);
        slv_ready = '0;
        step(3);
        // multiple low chip selects
`ifdef BUS_READ_MUX_MULTIHIT_ERR_EN
        issue(4'b1010, 32'h0, 1'b1, 1, 1);
`else
        issue(4'b1010, 32'h12345670, 1'b0, 4, 1);
`endif
        step(2);
        drive(0, 32'h12345670); drive(2, 32'h22222222);
        step(1);
        slv_ready = '0;
        step(4);
        // reset mid-WAIT drops the read
        issue(4'b1011, 32'h0, 1'b0, 0, 0);
        step(2);
        rst = 1'b1;
        #1;
        chk("midrst_data", read_data, 32'h0);
        chk("midrst_valid", {31'b0, read_valid}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        drive(2, 32'h77777777);
        step(1);
        slv_ready = '0;
        rst = 1'b0;
        issue(4'b1110, 32'h0A0B0C0D, 1'b0, 3, 1);
        step(1);
        drive(0, 32'h0A0B0C0D);
        step(1);
        slv_ready = '0;
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
        end
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_read_mux.md
BUS_READ_MUX -- requirements
Module: bus_read_mux

Interface
REQ-001 Parameter NUM_SLV, default 4: number of peripheral slaves, 2..16.
REQ-002 Parameter DW, default 32: read-data width.
REQ-003 Parameter TIMEOUT, default 16: maximum WAIT cycles before a timeout error, 1..255.
REQ-004 Clock `clk`, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Reset `rst`, input, 1 bit: asynchronous, active-high.
REQ-006 `rd_en`, input, 1 bit: read request strobe from the core, one cycle.
REQ-007 `cs_n`, input, NUM_SLV bits: active-low chip selects; bit i selects slave i.
REQ-008 `slv_rdata`, input, NUM_SLV*DW bits: slave i drives bits [i*DW +: DW].
REQ-009 `slv_ready`, input, NUM_SLV bits: slave i has valid read data this cycle.
REQ-010 `read_data`, output, DW bits: registered read data returned to the core.
REQ-011 `read_valid`, output, 1 bit: one-cycle response pulse.
REQ-012 `read_err`, output, 1 bit: error qualifier; meaningful only while read_valid=1.
REQ-013 `busy`, output, 1 bit: a transaction is outstanding (state != IDLE).

Function
REQ-014 FSM states: IDLE, WAIT, RESP; encoding is free; busy=1 in WAIT and RESP.
REQ-015 IDLE, rd_en=1, at least one cs_n bit low: latch the lowest-index low cs_n bit as sel, clear the timeout counter, go to WAIT.
REQ-016 IDLE, rd_en=1, all cs_n bits high (decode error): go to RESP with read_data<=0 and err<=1.
REQ-017 WAIT, slv_ready[sel]=1: capture slv_rdata[sel] into read_data, err<=0, go to RESP; slv_ready/slv_rdata of other slaves are ignored.
REQ-018 WAIT, slv_ready[sel]=0: increment the counter; when the counter reaches TIMEOUT, capture read_data<=0 and err<=1, go to RESP.
REQ-019 Simultaneous ready and timeout in the same WAIT cycle: ready wins and err=0.
REQ-020 RESP: read_valid=1 and read_err=err for exactly one cycle, then go to IDLE unconditionally.
REQ-021 Minimum latency: rd_en in cycle n, ready in cycle n+1, read_valid in cycle n+2.
REQ-022 Maximum latency: read_valid in cycle n+TIMEOUT+1.
REQ-023 rd_en while busy=1 is ignored: no queueing and no effect on the current transaction.
REQ-024 read_data holds its last value between responses.
REQ-025 cs_n changes after the rd_en cycle do not alter sel.
REQ-026 The counter width is the minimum needed to hold TIMEOUT, and the counter never wraps.

Reset
REQ-027 While rst=1: state=IDLE, read_data=0, read_valid=0, read_err=0, busy=0, counter=0, sel=0.
REQ-028 Reset asserted mid-transaction drops the pending read; no read_valid is produced for it after reset release.
REQ-029 rd_en in the first cycle after rst deasserts is accepted normally.

Configuration
REQ-030 Macro BUS_READ_MUX_MULTIHIT_ERR_EN, when defined: rd_en in IDLE with more than one cs_n bit low is a decode error (RESP, data 0, err 1) and no slave is selected.
REQ-031 Without BUS_READ_MUX_MULTIHIT_ERR_EN, multiple low cs_n bits resolve by priority: the lowest index wins and no error is reported.

Verification
REQ-032 NUM_SLV=4, cs_n=4'b1101, rd_en, slv_ready[1]=1 next cycle with data 32'hDEADBEEF -> read_valid=1, read_data=32'hDEADBEEF, read_err=0 two cycles after rd_en.
REQ-033 cs_n=4'b1111, rd_en -> next cycle read_valid=1, read_data=0, read_err=1.
REQ-034 TIMEOUT=16, cs_n=4'b0111, slv_ready=0 throughout -> read_valid with read_err=1 and read_data=0 exactly 17 cycles after rd_en; ready asserted on the 16th WAIT cycle -> valid data with err=0.
REQ-035 cs_n=4'b1010, rd_en -> slave 0 selected without the macro; with the macro defined -> decode error response.
REQ-036 rd_en pulses while busy -> exactly one read_valid; rst asserted during WAIT -> outputs 0 immediately and no read_valid after release.
